// File: rtl/receiver_tx_arbiter.sv
// Shares one serial transmitter among NUM_RECEIVERS decoder channels.
// Each channel captures into a one-entry slot; full slots are offered round-robin.
module receiver_tx_arbiter #(
    parameter int NUM_RECEIVERS = 4,
    parameter int ID_WIDTH      = 2
) (
    input  logic                          clk_96MHz,
    input  logic                          reset,
    input  logic [NUM_RECEIVERS-1:0]      data_availible,
    input  logic [17*NUM_RECEIVERS-1:0]   decoded_data,
    input  logic [24*NUM_RECEIVERS-1:0]   timestamp_last_data,
    output logic [NUM_RECEIVERS-1:0]      reset_decoder,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [ID_WIDTH-1:0]           tx_receiver_id,
    output logic [16:0]                   tx_decoded_data,
    output logic [23:0]                   tx_timestamp,
    output logic [NUM_RECEIVERS-1:0]      backpressure
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t state_reg, state_next;

    logic [NUM_RECEIVERS-1:0] slot_full_reg;
    logic [NUM_RECEIVERS-1:0] armed_reg;
    logic [NUM_RECEIVERS-1:0] reset_decoder_reg;
    logic [NUM_RECEIVERS-1:0] backpressure_reg;
    logic [NUM_RECEIVERS-1:0] capture;
    logic [NUM_RECEIVERS-1:0] slot_clear;
    logic [16:0]              slot_data_reg [NUM_RECEIVERS];
    logic [23:0]              slot_ts_reg   [NUM_RECEIVERS];

    logic [ID_WIDTH-1:0] rr_pointer_reg, rr_pointer_next;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH-1:0] cand;
    logic                grant_found;
    logic                handshake;

    logic                tx_valid_reg, tx_valid_next;
    logic [ID_WIDTH-1:0] tx_id_reg, tx_id_next;
    logic [16:0]         tx_data_reg, tx_data_next;
    logic [23:0]         tx_ts_reg, tx_ts_next;

    // Per-channel holding slot. A slot can never capture and clear on the same
    // edge: capture needs it empty, clearing needs it full.
    generate
        for (genvar gi = 0; gi < NUM_RECEIVERS; gi++) begin : g_chan
            assign capture[gi]    = data_availible[gi] & ~slot_full_reg[gi] & armed_reg[gi];
            assign slot_clear[gi] = handshake && (tx_id_reg == ID_WIDTH'(gi));

            always_ff @(posedge clk_96MHz) begin
                if (reset) begin
                    slot_full_reg[gi]     <= 1'b0;
                    armed_reg[gi]         <= 1'b1;
                    reset_decoder_reg[gi] <= 1'b1;
                    backpressure_reg[gi]  <= 1'b0;
                    slot_data_reg[gi]     <= '0;
                    slot_ts_reg[gi]       <= '0;
                end else begin
                    reset_decoder_reg[gi] <= capture[gi];
                    backpressure_reg[gi]  <= data_availible[gi] & armed_reg[gi] & slot_full_reg[gi];
                    // Rearm only once the decoder has visibly dropped its result.
                    if (!data_availible[gi]) begin
                        armed_reg[gi] <= 1'b1;
                    end else if (capture[gi]) begin
                        armed_reg[gi] <= 1'b0;
                    end
                    if (capture[gi]) begin
                        slot_full_reg[gi] <= 1'b1;
                        slot_data_reg[gi] <= decoded_data[17*gi +: 17];
                        slot_ts_reg[gi]   <= timestamp_last_data[24*gi +: 24];
                    end else if (slot_clear[gi]) begin
                        slot_full_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Descending scan so the full slot closest to rr_pointer wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_RECEIVERS - 1; i >= 0; i--) begin
            cand = ID_WIDTH'((int'(rr_pointer_reg) + i) % NUM_RECEIVERS);
            if (slot_full_reg[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_pointer_next = rr_pointer_reg;
        tx_valid_next   = tx_valid_reg;
        tx_id_next      = tx_id_reg;
        tx_data_next    = tx_data_reg;
        tx_ts_next      = tx_ts_reg;
        handshake       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    tx_valid_next = 1'b1;
                    tx_id_next    = grant_idx;
                    tx_data_next  = slot_data_reg[grant_idx];
                    tx_ts_next    = slot_ts_reg[grant_idx];
                    state_next    = OFFER;
                end
            end
            OFFER: begin
                if (tx_valid_reg && tx_ready) begin
                    handshake       = 1'b1;
                    tx_valid_next   = 1'b0;
                    rr_pointer_next = ID_WIDTH'((int'(tx_id_reg) + 1) % NUM_RECEIVERS);
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_reg      <= IDLE;
            rr_pointer_reg <= '0;
            tx_valid_reg   <= 1'b0;
            tx_id_reg      <= '0;
            tx_data_reg    <= '0;
            tx_ts_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            rr_pointer_reg <= rr_pointer_next;
            tx_valid_reg   <= tx_valid_next;
            tx_id_reg      <= tx_id_next;
            tx_data_reg    <= tx_data_next;
            tx_ts_reg      <= tx_ts_next;
        end
    end

    assign reset_decoder   = reset_decoder_reg;
    assign backpressure    = backpressure_reg;
    assign tx_valid        = tx_valid_reg;
    assign tx_receiver_id  = tx_id_reg;
    assign tx_decoded_data = tx_data_reg;
    assign tx_timestamp    = tx_ts_reg;

endmodule

// File: tb/tb_receiver_tx_arbiter.sv
// Bench for receiver_tx_arbiter: cycle table for a single capture, a scoreboard
// of expected transmitter words, and hand-written multi-cycle corner cases.
module tb_receiver_tx_arbiter;

    localparam int N = 4;

    logic          clk_96MHz = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  data_availible = '0;
    logic [17*N-1:0] decoded_data = '0;
    logic [24*N-1:0] timestamp_last_data = '0;
    logic [N-1:0]  reset_decoder;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [1:0]    tx_receiver_id;
    logic [16:0]   tx_decoded_data;
    logic [23:0]   tx_timestamp;
    logic [N-1:0]  backpressure;

    always #5 clk_96MHz = ~clk_96MHz;

    receiver_tx_arbiter #(.NUM_RECEIVERS(N), .ID_WIDTH(2)) dut (
        .clk_96MHz           (clk_96MHz),
        .reset               (reset),
        .data_availible      (data_availible),
        .decoded_data        (decoded_data),
        .timestamp_last_data (timestamp_last_data),
        .reset_decoder       (reset_decoder),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .tx_receiver_id      (tx_receiver_id),
        .tx_decoded_data     (tx_decoded_data),
        .tx_timestamp        (tx_timestamp),
        .backpressure        (backpressure)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [16:0] data;
        logic [23:0] ts;
    } tx_word_t;

    typedef struct {
        logic [3:0] dav;
        logic       rdy;
        logic [3:0] exp_rd;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic [3:0] exp_bp;
    } vec_t;

    tx_word_t exp_q[$];
    tx_word_t mon_word;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_96MHz);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [16:0] d, input logic [23:0] t);
        decoded_data[17*k +: 17]        = d;
        timestamp_last_data[24*k +: 24] = t;
    endtask

    task automatic push(input logic [1:0] id, input logic [16:0] d, input logic [23:0] t);
        tx_word_t e;
        e.id   = id;
        e.data = d;
        e.ts   = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: timeout with %0d words pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_availible = '0;
        tx_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_decoder", 64'(reset_decoder), 64'hF);
            chk("rst_valid", 64'(tx_valid), 64'd0);
            chk("rst_bp", 64'(backpressure), 64'd0);
        end
        reset = 1'b0;
        chk("release_decoder", 64'(reset_decoder), 64'hF);
        tick();
        chk("post_release_decoder", 64'(reset_decoder), 64'd0);
        chk("post_release_valid", 64'(tx_valid), 64'd0);
        chk("post_release_id", 64'(tx_receiver_id), 64'd0);
        chk("post_release_data", 64'(tx_decoded_data), 64'd0);
        chk("post_release_ts", 64'(tx_timestamp), 64'd0);
        chk("post_release_bp", 64'(backpressure), 64'd0);
        exp_q.delete();
    endtask

    // Scoreboard: a handshake completes on the edge following this sample.
    always @(negedge clk_96MHz) begin
        if (!reset && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            $display("tx id=%0d data=%05h ts=%06h", tx_receiver_id, tx_decoded_data, tx_timestamp);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx: got id %0d, expected no transfer", tx_receiver_id);
            end else begin
                mon_word = exp_q.pop_front();
                chk("tx_id", 64'(tx_receiver_id), 64'(mon_word.id));
                chk("tx_data", 64'(tx_decoded_data), 64'(mon_word.data));
                chk("tx_ts", 64'(tx_timestamp), 64'(mon_word.ts));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
        vecs[1] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 4'b0000};
        vecs[2] = '{4'b0100, 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000};
        vecs[3] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
        vecs[4] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
        vecs[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
        vecs[6] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 4'b0000};
        vecs[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000};
        vecs[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};

        // Single capture on ch2, held level, then rearm and recapture.
        do_reset();
        set_ch(2, 17'h1ABCD, 24'h123456);
        push(2'd2, 17'h1ABCD, 24'h123456);
        push(2'd2, 17'h1ABCD, 24'h123456);
        for (int i = 0; i < 9; i++) begin
            data_availible = vecs[i].dav;
            tx_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_rd", i), 64'(reset_decoder), 64'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_valid", i), 64'(tx_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_bp", i), 64'(backpressure), 64'(vecs[i].exp_bp));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_id", i), 64'(tx_receiver_id), 64'(vecs[i].exp_id));
        end
        wait_drain(5, "single_drain");

        // Round robin: all four at once, then ch0 and ch3.
        do_reset();
        for (int k = 0; k < N; k++) begin
            set_ch(k, 17'(17'h10000 + k * 17'h111), 24'(24'hA00000 + k));
            push(2'(k), 17'(17'h10000 + k * 17'h111), 24'(24'hA00000 + k));
        end
        data_availible = 4'b1111;
        tick();
        data_availible = 4'b0000;
        chk("rr_all_capture_rd", 64'(reset_decoder), 64'hF);
        tx_ready = 1'b1;
        wait_drain(40, "rr_all_drain");
        set_ch(0, 17'h00AAA, 24'h0000AA);
        set_ch(3, 17'h00333, 24'h000333);
        push(2'd0, 17'h00AAA, 24'h0000AA);
        push(2'd3, 17'h00333, 24'h000333);
        data_availible = 4'b1001;
        tick();
        data_availible = 4'b0000;
        chk("rr_pair_capture_rd", 64'(reset_decoder), 64'h9);
        wait_drain(20, "rr_pair_drain");

        // Stall on ch1 with a second ch1 result backpressured.
        do_reset();
        set_ch(1, 17'h05A5A, 24'hC0FFEE);
        data_availible = 4'b0010;
        tick();
        data_availible = 4'b0000;
        tick();
        push(2'd1, 17'h05A5A, 24'hC0FFEE);
        chk("stall_valid_start", 64'(tx_valid), 64'd1);
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                set_ch(1, 17'h0BEEF, 24'h00BEEF);
                data_availible = 4'b0010;
            end
            tick();
            chk("stall_valid", 64'(tx_valid), 64'd1);
            chk("stall_id", 64'(tx_receiver_id), 64'd1);
            chk("stall_data", 64'(tx_decoded_data), 64'h05A5A);
            chk("stall_ts", 64'(tx_timestamp), 64'hC0FFEE);
            chk("stall_no_rd", 64'(reset_decoder), 64'd0);
            if (i >= 10)
                chk("stall_bp", 64'(backpressure), 64'h2);
        end
        push(2'd1, 17'h0BEEF, 24'h00BEEF);
        tx_ready = 1'b1;
        tick();
        chk("stall_free_no_rd", 64'(reset_decoder), 64'd0);
        tick();
        chk("stall_recapture_rd", 64'(reset_decoder), 64'h2);
        chk("stall_recapture_bp", 64'(backpressure), 64'd0);
        data_availible = 4'b0000;
        wait_drain(10, "stall_drain");

        // Handshake on ch0 coinciding with a rearmed ch0 result.
        do_reset();
        set_ch(0, 17'h11111, 24'h111111);
        data_availible = 4'b0001;
        tick();
        data_availible = 4'b0000;
        tick();
        chk("coll_offer_valid", 64'(tx_valid), 64'd1);
        push(2'd0, 17'h11111, 24'h111111);
        set_ch(0, 17'h02222, 24'h222222);
        data_availible = 4'b0001;
        tx_ready = 1'b1;
        tick();
        chk("coll_no_same_cycle_rd", 64'(reset_decoder), 64'd0);
        chk("coll_valid_drop", 64'(tx_valid), 64'd0);
        tick();
        chk("coll_capture_rd", 64'(reset_decoder), 64'h1);
        data_availible = 4'b0000;
        push(2'd0, 17'h02222, 24'h222222);
        wait_drain(10, "coll_drain");

        // Reset in OFFER with three full slots and rr_pointer away from 0.
        do_reset();
        set_ch(1, 17'h00001, 24'h000001);
        set_ch(2, 17'h00002, 24'h000002);
        set_ch(3, 17'h00003, 24'h000003);
        data_availible = 4'b1110;
        tick();
        data_availible = 4'b0000;
        tick();
        push(2'd1, 17'h00001, 24'h000001);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        chk("mid_offer_valid", 64'(tx_valid), 64'd1);
        chk("mid_offer_id", 64'(tx_receiver_id), 64'd2);
        set_ch(0, 17'h00F00, 24'h000F00);
        data_availible = 4'b0001;
        tick();
        data_availible = 4'b0000;
        reset = 1'b1;
        tick();
        chk("mid_reset_valid", 64'(tx_valid), 64'd0);
        chk("mid_reset_id", 64'(tx_receiver_id), 64'd0);
        chk("mid_reset_data", 64'(tx_decoded_data), 64'd0);
        do_reset();
        repeat (3) begin
            tick();
            chk("post_reset_empty", 64'(tx_valid), 64'd0);
        end
        set_ch(0, 17'h0C0C0, 24'h0C0C0C);
        set_ch(3, 17'h03C3C, 24'h03C3C3);
        push(2'd0, 17'h0C0C0, 24'h0C0C0C);
        push(2'd3, 17'h03C3C, 24'h03C3C3);
        data_availible = 4'b1001;
        tick();
        data_availible = 4'b0000;
        tx_ready = 1'b1;
        wait_drain(20, "post_reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receiver_tx_arbiter.md
Name: receiver_tx_arbiter

Overview:
- Shares the single UART serial transmitter among NUM_RECEIVERS single_receiver_manager instances.
- Each channel has a one-entry holding slot. A capture latches decoded_data and timestamp_last_data and pulses that channel's decoder reset.
- Full slots are granted to the transmitter round-robin over a valid/ready handshake, tagged with the channel id.
- Sits between the receiver managers and serial_transmitter in the top level, all in the clk_96MHz domain. tx_ready is synchronised externally.

Parameters:
- NUM_RECEIVERS, 4, number of receiver channels (2..8).
- ID_WIDTH, 2, width of the channel id; must satisfy 2^ID_WIDTH >= NUM_RECEIVERS.

Ports:
- clk_96MHz  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_availible  input  NUM_RECEIVERS  per-channel level; high while the decoder holds a result.
- decoded_data  input  17*NUM_RECEIVERS  channel k occupies bits [17k+16:17k].
- timestamp_last_data  input  24*NUM_RECEIVERS  channel k occupies bits [24k+23:24k].
- reset_decoder  output  NUM_RECEIVERS  per-channel decoder reset/release.
- tx_valid  output  1  offer to the transmitter.
- tx_ready  input  1  transmitter can accept.
- tx_receiver_id  output  ID_WIDTH  channel of the offered word.
- tx_decoded_data  output  17  offered data.
- tx_timestamp  output  24  offered timestamp.
- backpressure  output  NUM_RECEIVERS  channel waiting because its slot is full.

Behaviour:
- Reset (any cycle, including mid-handshake):
  - All slots empty, all armed flags set.
  - rr_pointer=0, state=IDLE.
  - tx_valid=0; tx_receiver_id, tx_decoded_data and tx_timestamp = 0.
  - backpressure=0.
  - reset_decoder = all ones while reset is high, and for exactly one cycle after reset deasserts, so every decoder is cleared.
- Capture, per channel k:
  - Condition, evaluated on registered state: data_availible[k]=1, slot_full[k]=0 and armed[k]=1.
  - Cycle t satisfies the condition. At t+1: slot_data[k] and slot_ts[k] hold the values sampled at t, slot_full[k]=1, armed[k]=0, and reset_decoder[k] is high for exactly one cycle.
  - armed[k] returns to 1 only after data_availible[k] is sampled low. This prevents double capture while the decoder reacts to its reset.
- Backpressure:
  - backpressure[k] is registered: 1 when data_availible[k]=1, armed[k]=1 and slot_full[k]=1 in the previous cycle.
  - The decoder is not reset, so it holds its result. No data is lost.
- Arbiter FSM with states IDLE, OFFER:
  - IDLE: if any slot is full, grant the first full slot searching from rr_pointer upward with wrap-around. Load the tx_* outputs from that slot and set tx_valid=1 on the next edge, then go to OFFER. Grant latency from slot_full to tx_valid is 1 cycle.
  - OFFER: tx_valid, tx_receiver_id and the tx payload are held stable until a cycle with tx_valid=1 and tx_ready=1. On that edge: slot_full[grant]=0, rr_pointer=(grant+1) mod NUM_RECEIVERS, tx_valid=0, state=IDLE.
  - Minimum spacing between transfers is 2 cycles (IDLE, OFFER).
  - tx_ready high in IDLE has no effect.
- Simultaneous events:
  - A slot cleared by a handshake on cycle t is not re-captured in cycle t. It may capture from cycle t+1.
  - Captures on several channels in one cycle are all accepted independently.
  - A capture into a non-granted slot during OFFER does not disturb the offered payload.
- Widths:
  - rr_pointer is ID_WIDTH bits; wrap occurs at NUM_RECEIVERS, not at 2^ID_WIDTH.
  - Ids >= NUM_RECEIVERS are never emitted.

Test Plan:
- Reset release: reset high 3 cycles, then low -> reset_decoder=4'b1111 through the first cycle after release, then 4'b0000; tx_valid=0 and backpressure=0 throughout.
- Single capture: ch2 data_availible=1 with decoded_data=17'h1ABCD and timestamp=24'h123456 at cycle t, tx_ready=1 -> reset_decoder=4'b0100 at t+1 only; tx_valid at t+2 with id=2 and payload 1ABCD/123456; slot cleared after the handshake; no second capture while data_availible remains high until it drops.
- Round robin: all 4 channels captured in the same cycle, tx_ready=1 -> ids emitted 0,1,2,3. Then ch0 and ch3 recaptured -> order 0,3.
- Stall: tx_ready=0 for 50 cycles while offering ch1 -> tx_valid, id=1 and payload held stable all 50 cycles. A new ch1 result -> backpressure[1]=1 and no reset_decoder[1] pulse until ch1's slot is freed and recaptured.
- Clear/capture collision: handshake on ch0 at cycle t with a rearmed ch0 data_availible=1 at t -> capture at t+1, reset_decoder[0] pulse at t+2.
- Reset mid-OFFER: reset during OFFER with 3 full slots -> tx_valid=0 next cycle; all slots empty; first grant after reset starts from ch0.
